// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver, LSB first, mid-bit sampling.
//
// Samples the asynchronous serial line through a 2-flop synchronizer and
// delivers each received byte with a one-cycle ready strobe.
//
// Optional feature macro: UART_RX_FRAME_ERR_EN
//   defined   : a stop bit sampled low raises o_frame_err for one cycle instead
//               of delivering the byte, then the receiver waits for the line to
//               return high before hunting for the next start bit.
//   undefined : stop bit value ignored; every completed frame is delivered.
//
// Ports:
//   i_clk          system clock, all state on posedge
//   i_rst_n        asynchronous active-low reset
//   i_rx           serial line, asynchronous, idle high
//   o_rx_byte      last correctly received byte (held between deliveries)
//   o_rx_byte_rdy  one-cycle pulse, o_rx_byte was just updated
//   o_rx_busy      high from start-bit detection through the CLEANUP cycle
//   o_frame_err    one-cycle pulse on a bad stop bit (feature only)
module uart_rx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_byte_rdy,
  output logic       o_rx_busy
`ifdef UART_RX_FRAME_ERR_EN
  ,
  output logic       o_frame_err
`endif
);

  // Half-bit point used to re-check the start bit, and the per-bit terminal count.
  localparam logic [13:0] HALF = 14'((CLKS_PER_BIT - 1) / 2);
  localparam logic [13:0] TC   = 14'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    CLEANUP
`ifdef UART_RX_FRAME_ERR_EN
    ,
    WAIT_IDLE
`endif
  } state_t;

  logic        rx_meta, rxs;
  state_t      state, state_n;
  logic [13:0] cnt, cnt_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shreg, shreg_n;
  logic [7:0]  byte_q, byte_n;
  logic        rdy_q, rdy_n;
  logic        busy_q, busy_n;
`ifdef UART_RX_FRAME_ERR_EN
  logic        ferr_q, ferr_n;
`endif

  // Synchronizer resets to the idle (high) line level so reset release
  // never looks like a start bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      byte_q  <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      ferr_q  <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      byte_q  <= byte_n;
      rdy_q   <= rdy_n;
      busy_q  <= busy_n;
`ifdef UART_RX_FRAME_ERR_EN
      ferr_q  <= ferr_n;
`endif
    end
  end

  // The delivery decision is taken at the stop-bit sample, so the byte and
  // strobe are registered on entry to CLEANUP and are visible for exactly
  // the CLEANUP cycle.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    byte_n    = byte_q;
    rdy_n     = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
    ferr_n    = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_n     = '0;
        bit_idx_n = '0;
        if (!rxs) state_n = START;
      end
      START: begin
        if (cnt == HALF) begin
          cnt_n   = '0;
          // Line back high at mid start bit: treat as a glitch.
          state_n = rxs ? IDLE : DATA;
        end else begin
          cnt_n = cnt + 14'd1;
        end
      end
      DATA: begin
        if (cnt == TC) begin
          cnt_n            = '0;
          shreg_n[bit_idx] = rxs;
          if (bit_idx == 3'd7) begin
            bit_idx_n = '0;
            state_n   = STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          cnt_n = cnt + 14'd1;
        end
      end
      STOP: begin
        if (cnt == TC) begin
          cnt_n   = '0;
          state_n = CLEANUP;
`ifdef UART_RX_FRAME_ERR_EN
          if (!rxs) begin
            ferr_n = 1'b1;
          end else begin
            byte_n = shreg;
            rdy_n  = 1'b1;
          end
`else
          byte_n = shreg;
          rdy_n  = 1'b1;
`endif
        end else begin
          cnt_n = cnt + 14'd1;
        end
      end
      CLEANUP: begin
`ifdef UART_RX_FRAME_ERR_EN
        // After a bad stop bit the line may be in a break; hold off until
        // it returns high so a break gives a single error pulse.
        state_n = ferr_q ? WAIT_IDLE : IDLE;
`else
        state_n = IDLE;
`endif
      end
`ifdef UART_RX_FRAME_ERR_EN
      WAIT_IDLE: begin
        if (rxs) state_n = IDLE;
      end
`endif
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  assign o_rx_byte     = byte_q;
  assign o_rx_byte_rdy = rdy_q;
  assign o_rx_busy     = busy_q;
`ifdef UART_RX_FRAME_ERR_EN
  assign o_frame_err   = ferr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at CLKS_PER_BIT=16. Builds with or without
// UART_RX_FRAME_ERR_EN; expectations follow the selected configuration.
module tb_uart_rx;
  localparam int CPB = 16;
  localparam int H   = (CPB - 1) / 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] rx_byte;
  logic       rdy, busy;
`ifdef UART_RX_FRAME_ERR_EN
  logic       ferr;
  int         ferr_cnt = 0;
`endif

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_rx         (rx),
    .o_rx_byte    (rx_byte),
    .o_rx_byte_rdy(rdy),
    .o_rx_busy    (busy)
`ifdef UART_RX_FRAME_ERR_EN
    ,
    .o_frame_err  (ferr)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: log every strobe cycle with its byte and cycle stamp.
  logic [7:0] rxq[$];
  int         rdy_cyc[$];
  int         busy_cyc = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (rdy) begin
        rxq.push_back(rx_byte);
        rdy_cyc.push_back(cyc);
      end
      if (busy) busy_cyc++;
`ifdef UART_RX_FRAME_ERR_EN
      if (ferr) ferr_cnt++;
`endif
    end
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] q_at(input int i);
    if (i >= 0 && i < rxq.size()) return {24'd0, rxq[i]};
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] cyc_at(input int i);
    if (i >= 0 && i < rdy_cyc.size()) return rdy_cyc[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] q_last(input int base);
    if (rxq.size() > base) return {24'd0, rxq[rxq.size()-1]};
    return 32'hDEAD_BEEF;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_byte"}, rx_byte, 8'h00);
    chk({tag, "_rdy"},  rdy,     1'b0);
    chk({tag, "_busy"}, busy,    1'b0);
`ifdef UART_RX_FRAME_ERR_EN
    chk({tag, "_ferr"}, ferr,    1'b0);
`endif
  endtask

  // Drive one 10-bit frame from a negedge; optionally assert reset at a
  // given cycle offset into the frame (-1: never).
  task automatic send_frame(input logic [7:0] b, input logic stopb, input int rst_at);
    logic [9:0] bits;
    bits = {stopb, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < CPB; c++) begin
        rx = bits[i];
        if (i * CPB + c == rst_at) begin
          rst_n = 1'b0;
          #1;
          chk_reset_outs("midrst");
        end
        @(negedge clk);
      end
    end
    rx = 1'b1;
  endtask

  int base, t0, b0, zeros;

  initial begin
    idle(3);
    chk_reset_outs("reset");
    rst_n = 1'b1;
    idle(20);

    // Single frame with exact strobe timing: edge E = t0+1, strobe sampled
    // in the cycle after edge E+3+H+9*CPB.
    base = rxq.size();
    t0   = cyc;
    send_frame(8'hA5, 1'b1, -1);
    idle(40);
    chk("a5_count", rxq.size() - base, 1);
    chk("a5_byte",  q_at(base), 8'hA5);
    chk("a5_lat",   cyc_at(base), t0 + 1 + 3 + 7 + 144);
    chk("a5_busy",  busy, 1'b0);

    // Back-to-back, no idle gap.
    base = rxq.size();
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    send_frame(8'h5A, 1'b1, -1);
    idle(40);
    chk("b2b_count", rxq.size() - base, 3);
    chk("b2b_0", q_at(base),     8'h00);
    chk("b2b_1", q_at(base + 1), 8'hFF);
    chk("b2b_2", q_at(base + 2), 8'h5A);

    // Glitch: 4 low cycles; START lasts H+1 cycles then aborts.
    base = rxq.size();
    b0   = busy_cyc;
    rx   = 1'b0;
    idle(4);
    rx   = 1'b1;
    idle(40);
    chk("glitch_rdy",  rxq.size() - base, 0);
    chk("glitch_busy", busy_cyc - b0, H + 1);
    chk("glitch_byte", rx_byte, 8'h5A);
    send_frame(8'h3C, 1'b1, -1);
    idle(40);
    chk("post_glitch", q_at(base), 8'h3C);

    // Distinct prior value, then a frame with a low stop bit.
    send_frame(8'h55, 1'b1, -1);
    idle(40);
    chk("pre_ferr", rx_byte, 8'h55);
    base = rxq.size();
`ifdef UART_RX_FRAME_ERR_EN
    b0 = ferr_cnt;
`endif
    send_frame(8'h3C, 1'b0, -1);
    idle(40);
`ifdef UART_RX_FRAME_ERR_EN
    chk("ferr_pulse", ferr_cnt - b0, 1);
    chk("ferr_rdy",   rxq.size() - base, 0);
    chk("ferr_byte",  rx_byte, 8'h55);
`else
    chk("ferr_rdy",   rxq.size() - base, 1);
    chk("ferr_byte",  q_at(base), 8'h3C);
`endif

    // Break: 40 bit times low, then a normal frame.
    base = rxq.size();
`ifdef UART_RX_FRAME_ERR_EN
    b0 = ferr_cnt;
`endif
    rx = 1'b0;
    idle(40 * CPB);
    rx = 1'b1;
`ifdef UART_RX_FRAME_ERR_EN
    idle(4);
    chk("brk_busy", busy, 1'b0);
`endif
    idle(400);
    send_frame(8'h81, 1'b1, -1);
    idle(40);
    chk("brk_last", q_last(base), 8'h81);
`ifdef UART_RX_FRAME_ERR_EN
    chk("brk_ferr",  ferr_cnt - b0, 1);
    chk("brk_count", rxq.size() - base, 1);
`else
    // Frame restarts every 154 cycles while low: four full zero frames fit.
    zeros = 0;
    for (int i = base; i < rxq.size(); i++) if (rxq[i] == 8'h00) zeros++;
    chk("brk_zeros", zeros, 4);
`endif

    // Reset in the middle of data bit 3, held until the frame is over.
    idle(20);
    base = rxq.size();
    send_frame(8'hC3, 1'b1, 4 * CPB + CPB / 2);
    idle(5);
    chk_reset_outs("held_rst");
    rst_n = 1'b1;
    idle(20);
    chk("rst_nostrobe", rxq.size() - base, 0);
    send_frame(8'h12, 1'b1, -1);
    idle(40);
    chk("rst_count", rxq.size() - base, 1);
    chk("rst_byte",  q_at(base), 8'h12);
    chk("rst_hold",  rx_byte, 8'h12);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
